i2s_sample_recorder: RTL

- Upstream stage of the sample collector in the audio record/playback path.
- Deserialises I2S ADC data from the codec into DATA_W-bit samples.
- Writes samples sequentially into sample memory from address 0 upward; the collector later reads that memory back.
- Runs on the system clock; codec bit-clock and frame-clock are treated as sampled data inputs, not clocks.

---
 rtl/i2s_sample_recorder.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/i2s_sample_recorder.sv
// i2s_sample_recorder: deserialises I2S ADC words into DATA_W-bit samples and writes them to memory from address 0.
// Optional build macro RECORDER_MONO_MIX_EN: capture left and right words and store their signed average.
module i2s_sample_recorder #(
  parameter int ADDR_W   = 20,
  parameter int DATA_W   = 8,
  parameter int MAX_ADDR = 2**ADDR_W-1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic              i_stop,
  input  logic              i_bclk,
  input  logic              i_lrck,
  input  logic              i_adcdat,
  output logic [ADDR_W-1:0] o_addr,
  output logic [DATA_W-1:0] o_data,
  output logic              o_we,
  output logic              o_busy,
  output logic              o_done,
  output logic [ADDR_W:0]   o_len
);
  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(MAX_ADDR);

  typedef enum logic [2:0] {IDLE, ARM, SKIP, SHIFT, WRITE, DONE} state_t;
  state_t state, state_nx;

  logic [1:0]        bclk_s, lrck_s, dat_s;
  logic              bclk_d, bclk_rise, lrck_d, lrck_d2, dat_d;
  logic              lrck_fall, word_ev, last_word, last_bit;
  logic [ADDR_W-1:0] addr_cnt;
  logic [CNT_W-1:0]  bit_cnt;
  logic [DATA_W-2:0] sr;
  logic [DATA_W-1:0] sample, mixed;

  // The rise pulse is registered; lrck/data get one extra stage so all three stay aligned.
  always_ff @(posedge i_clk or negedge i_rst)
    if (!i_rst) begin
      bclk_s    <= '0;
      lrck_s    <= '0;
      dat_s     <= '0;
      bclk_d    <= 1'b0;
      bclk_rise <= 1'b0;
      lrck_d    <= 1'b0;
      lrck_d2   <= 1'b0;
      dat_d     <= 1'b0;
    end else begin
      bclk_s    <= {bclk_s[0], i_bclk};
      lrck_s    <= {lrck_s[0], i_lrck};
      dat_s     <= {dat_s[0], i_adcdat};
      bclk_d    <= bclk_s[1];
      bclk_rise <= bclk_s[1] & ~bclk_d;
      lrck_d    <= lrck_s[1];
      lrck_d2   <= lrck_d;
      dat_d     <= dat_s[1];
    end

  assign lrck_fall = lrck_d2 & ~lrck_d;
  assign sample    = {sr, dat_d};
  assign last_bit  = bclk_rise && (bit_cnt == CNT_W'(DATA_W-1));

`ifdef RECORDER_MONO_MIX_EN
  logic                   chan;
  logic [DATA_W-1:0]      left;
  logic signed [DATA_W:0] sum;
  assign sum       = $signed({left[DATA_W-1], left}) + $signed({sample[DATA_W-1], sample});
  assign mixed     = DATA_W'(sum >>> 1);
  assign word_ev   = chan ? (~lrck_d2 & lrck_d) : lrck_fall;
  assign last_word = chan;
`else
  assign mixed     = sample;
  assign word_ev   = lrck_fall;
  assign last_word = 1'b1;
`endif

  always_ff @(posedge i_clk or negedge i_rst)
    if (!i_rst) state <= IDLE;
    else        state <= state_nx;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE, DONE: if (i_start) state_nx = ARM;
      ARM:   if (i_stop) state_nx = DONE; else if (word_ev) state_nx = SKIP;
      SKIP:  if (i_stop) state_nx = DONE; else if (bclk_rise) state_nx = SHIFT;
      SHIFT: if (i_stop) state_nx = DONE; else if (last_bit) state_nx = last_word ? WRITE : ARM;
      WRITE: state_nx = (i_stop || addr_cnt == LAST) ? DONE : ARM;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    o_we   = 1'b0;
    o_busy = 1'b0;
    o_done = 1'b0;
    case (state)
      ARM, SKIP, SHIFT: o_busy = 1'b1;
      WRITE: begin o_busy = 1'b1; o_we = 1'b1; end
      DONE:  o_done = 1'b1;
      default: ;
    endcase
  end

  // Write address/data are loaded on entry to WRITE and then simply hold.
  always_ff @(posedge i_clk or negedge i_rst)
    if (!i_rst) begin
      addr_cnt <= '0;
      bit_cnt  <= '0;
      sr       <= '0;
      o_addr   <= '0;
      o_data   <= '0;
      o_len    <= '0;
`ifdef RECORDER_MONO_MIX_EN
      chan     <= 1'b0;
      left     <= '0;
`endif
    end else begin
      case (state)
        IDLE, DONE: if (i_start) begin
          addr_cnt <= '0;
          o_len    <= '0;
`ifdef RECORDER_MONO_MIX_EN
          chan     <= 1'b0;
`endif
        end
        SKIP: bit_cnt <= '0;
        SHIFT: if (bclk_rise && !i_stop) begin
          sr      <= sample[DATA_W-2:0];
          bit_cnt <= bit_cnt + 1'b1;
          if (last_bit && last_word) begin
            o_addr <= addr_cnt;
            o_data <= mixed;
            o_len  <= o_len + 1'b1;
          end
`ifdef RECORDER_MONO_MIX_EN
          if (last_bit && !chan) begin
            left <= sample;
            chan <= 1'b1;
          end
`endif
        end
        WRITE: begin
          if (addr_cnt != LAST) addr_cnt <= addr_cnt + 1'b1;
`ifdef RECORDER_MONO_MIX_EN
          chan <= 1'b0;
`endif
        end
        default: ;
      endcase
    end
endmodule
